load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 22 ++
 rtl/load_store_unit_byte_lane.sv | 42 ++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// byte-lane selectors and the word-address helper.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Wide enough for READ_LAT up to 4 (counter runs 0..READ_LAT-1)
    localparam int CNT_W = 2;

    function automatic logic [15:0] word_addr(input logic [15:0] byte_adr);
        return {1'b0, byte_adr[15:1]};
    endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Combinational byte-lane helper: merges a store byte into a word and
// extracts/extends a byte from a word for loads.
module byte_lane
    import load_store_unit_pkg::*;
(
    input  logic [15:0] i_word,
    input  logic        i_lane,
    input  logic [7:0]  i_byte,
    input  logic        i_sign,
    output logic [15:0] o_merged,
    output logic [15:0] o_extracted
);

    logic [7:0] w_sel;

    // Lane merge and extraction share one lane decode
    always_comb begin
        o_merged    = i_word;
        w_sel       = i_word[7:0];
        o_extracted = 16'h0000;
        case (i_lane)
            LANE_LO: begin
                o_merged = {i_word[15:8], i_byte};
                w_sel    = i_word[7:0];
            end
            LANE_HI: begin
                o_merged = {i_byte, i_word[7:0]};
                w_sel    = i_word[15:8];
            end
            default: begin
                o_merged = i_word;
                w_sel    = i_word[7:0];
            end
        endcase
        if (i_sign) begin
            o_extracted = {{8{w_sel[7]}}, w_sel};
        end else begin
            o_extracted = {8'h00, w_sel};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store unit driving a 16-bit word DataMemory with a fixed
// read latency; byte stores are done as read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        Store,
    input  logic        ByteOp,
    input  logic        SignExt,
    input  logic [15:0] Adresa,
    input  logic [15:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] ReadData,
    output logic [15:0] MemAdresa,
    output logic [15:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [15:0] MemReadData
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

    lsu_state_e       r_state;
    logic             r_store;
    logic             r_byte;
    logic             r_sext;
    logic [15:0]      r_adr;
    logic [15:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_capt;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_mem_read;
    logic             r_mem_write;

    logic [15:0]      w_merged;
    logic [15:0]      w_extracted;

    byte_lane u_byte_lane (
        .i_word      (r_capt),
        .i_lane      (r_adr[0]),
        .i_byte      (r_wdata[7:0]),
        .i_sign      (r_sext),
        .o_merged    (w_merged),
        .o_extracted (w_extracted)
    );

    // Transaction FSM; strobes and status are registered alongside the state
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_store     <= 1'b0;
            r_byte      <= 1'b0;
            r_sext      <= 1'b0;
            r_adr       <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_cnt       <= {CNT_W{1'b0}};
            r_capt      <= 16'h0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Req) begin
                        r_store <= Store;
                        r_byte  <= ByteOp;
                        r_sext  <= SignExt;
                        r_adr   <= Adresa;
                        r_wdata <= WriteData;
                        r_busy  <= 1'b1;
                        if (!ByteOp && Adresa[0]) begin
                            r_state <= RESP;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                        end else if (!Store || ByteOp) begin
                            r_state    <= RD;
                            r_mem_read <= 1'b1;
                            r_cnt      <= {CNT_W{1'b0}};
                        end else begin
                            r_state     <= WR;
                            r_mem_write <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD: begin
                    if (r_cnt == LAST_CNT) begin
                        r_capt     <= MemReadData;
                        r_mem_read <= 1'b0;
                        r_cnt      <= {CNT_W{1'b0}};
                        // Byte stores continue into the write half of the RMW
                        if (r_store) begin
                            r_state     <= WR;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state <= RESP;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                WR: begin
                    r_mem_write <= 1'b0;
                    r_state     <= RESP;
                    r_done      <= 1'b1;
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_error     <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Data-path outputs decoded purely from registered state
    always_comb begin
        MemAdresa    = 16'h0000;
        MemWriteData = 16'h0000;
        ReadData     = 16'h0000;
        if ((r_state == RD) || (r_state == WR)) begin
            MemAdresa = word_addr(r_adr);
        end else begin
            MemAdresa = 16'h0000;
        end
        if (r_state == WR) begin
            MemWriteData = r_byte ? w_merged : r_wdata;
        end else begin
            MemWriteData = 16'h0000;
        end
        if ((r_state == RESP) && !r_store && !r_error) begin
            ReadData = r_byte ? w_extracted : r_capt;
        end else begin
            ReadData = 16'h0000;
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Error    = r_error;
    assign MemRead  = r_mem_read;
    assign MemWrite = r_mem_write;

endmodule
